// File: rtl/instr_sequencer_pkg.sv
// ============================================================================
// instr_sequencer_pkg : opcodes, state encoding and datapath select codes
// Optional feature macro: JAL_EN (enables the JAL link-and-jump state)
// Revision: 1.0
// ============================================================================
`default_nettype none

package instr_sequencer_pkg;

    localparam logic [5:0] c_OP_RTYPE = 6'h00;
    localparam logic [5:0] c_OP_J     = 6'h02;
    localparam logic [5:0] c_OP_JAL   = 6'h03;
    localparam logic [5:0] c_OP_BEQ   = 6'h04;
    localparam logic [5:0] c_OP_BNE   = 6'h05;
    localparam logic [5:0] c_OP_ADDI  = 6'h08;
    localparam logic [5:0] c_OP_ANDI  = 6'h0c;
    localparam logic [5:0] c_OP_ORI   = 6'h0d;
    localparam logic [5:0] c_OP_LUI   = 6'h0f;
    localparam logic [5:0] c_OP_LW    = 6'h23;
    localparam logic [5:0] c_OP_SW    = 6'h2b;

    typedef logic [3:0] state_t;

    localparam state_t c_ST_FETCH    = 4'd0;
    localparam state_t c_ST_DECODE   = 4'd1;
    localparam state_t c_ST_MEM_ADDR = 4'd2;
    localparam state_t c_ST_MEM_RD   = 4'd3;
    localparam state_t c_ST_MEM_WB   = 4'd4;
    localparam state_t c_ST_MEM_WR   = 4'd5;
    localparam state_t c_ST_R_EXE    = 4'd6;
    localparam state_t c_ST_R_WB     = 4'd7;
    localparam state_t c_ST_BRANCH   = 4'd8;
    localparam state_t c_ST_JUMP     = 4'd9;
    localparam state_t c_ST_I_EXE    = 4'd10;
    localparam state_t c_ST_I_WB     = 4'd11;
    localparam state_t c_ST_JAL      = 4'd12;
    localparam state_t c_ST_HALT     = 4'd15;

    localparam logic [2:0] c_ALU_ADD   = 3'b000;
    localparam logic [2:0] c_ALU_SUB   = 3'b001;
    localparam logic [2:0] c_ALU_RTYPE = 3'b111;
    localparam logic [2:0] c_ALU_ADDI  = 3'b100;
    localparam logic [2:0] c_ALU_ORI   = 3'b101;
    localparam logic [2:0] c_ALU_ANDI  = 3'b110;
    localparam logic [2:0] c_ALU_LUI   = 3'b011;

    localparam logic [1:0] c_PCSRC_ALU    = 2'b00;
    localparam logic [1:0] c_PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] c_PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] c_SRCB_REGB  = 2'b00;
    localparam logic [1:0] c_SRCB_FOUR  = 2'b01;
    localparam logic [1:0] c_SRCB_IMM   = 2'b10;
    localparam logic [1:0] c_SRCB_SHIMM = 2'b11;

    localparam logic [1:0] c_REGDST_RT = 2'b00;
    localparam logic [1:0] c_REGDST_RD = 2'b01;
    localparam logic [1:0] c_REGDST_RA = 2'b10;

`ifdef JAL_EN
    localparam bit c_JAL_EN = 1'b1;
`else
    localparam bit c_JAL_EN = 1'b0;
`endif

    // DECODE successor; FETCH doubles as the "unsupported opcode" result.
    function automatic state_t decodeTarget(input logic [5:0] op);
        case (op)
            c_OP_LW, c_OP_SW:                      decodeTarget = c_ST_MEM_ADDR;
            c_OP_RTYPE:                            decodeTarget = c_ST_R_EXE;
            c_OP_BEQ, c_OP_BNE:                    decodeTarget = c_ST_BRANCH;
            c_OP_J:                                decodeTarget = c_ST_JUMP;
            c_OP_ADDI, c_OP_ANDI, c_OP_ORI, c_OP_LUI: decodeTarget = c_ST_I_EXE;
            c_OP_JAL:                              decodeTarget = c_JAL_EN ? c_ST_JAL : c_ST_FETCH;
            default:                               decodeTarget = c_ST_FETCH;
        endcase
    endfunction

    function automatic logic [2:0] iTypeAluOp(input logic [5:0] op);
        case (op)
            c_OP_ADDI: iTypeAluOp = c_ALU_ADDI;
            c_OP_ORI:  iTypeAluOp = c_ALU_ORI;
            c_OP_ANDI: iTypeAluOp = c_ALU_ANDI;
            c_OP_LUI:  iTypeAluOp = c_ALU_LUI;
            default:   iTypeAluOp = c_ALU_ADD;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/seq_outdecode.sv
// ============================================================================
// seq_outdecode : combinational state/OP/Zero/MemReady to datapath-control decode
// Optional feature macro: JAL_EN (via instr_sequencer_pkg::c_JAL_EN)
// Revision: 1.0
// ============================================================================
`default_nettype none

module seq_outdecode
    import instr_sequencer_pkg::*;
(
    input  state_t     i_state,
    input  logic [5:0] i_op,
    input  logic       i_zero,
    input  logic       i_memReady,
    output logic       o_pcWrite,
    output logic       o_iorD,
    output logic       o_irWrite,
    output logic       o_memRead,
    output logic       o_memWrite,
    output logic       o_memtoReg,
    output logic       o_aluSrcA,
    output logic       o_regWrite,
    output logic [1:0] o_pcSource,
    output logic [1:0] o_aluSrcB,
    output logic [1:0] o_regDst,
    output logic [2:0] o_aluOp,
    output logic       o_illegal
);

    always_comb begin
        o_pcWrite  = 1'b0;
        o_iorD     = 1'b0;
        o_irWrite  = 1'b0;
        o_memRead  = 1'b0;
        o_memWrite = 1'b0;
        o_memtoReg = 1'b0;
        o_aluSrcA  = 1'b0;
        o_regWrite = 1'b0;
        o_pcSource = c_PCSRC_ALU;
        o_aluSrcB  = c_SRCB_REGB;
        o_regDst   = c_REGDST_RT;
        o_aluOp    = c_ALU_ADD;
        o_illegal  = 1'b0;

        case (i_state)
            c_ST_FETCH: begin
                o_memRead = 1'b1;
                o_aluSrcB = c_SRCB_FOUR;
                o_aluOp   = c_ALU_ADD;
                o_irWrite = i_memReady;
                o_pcWrite = i_memReady;
            end
            c_ST_DECODE: begin
                o_aluSrcB = c_SRCB_SHIMM;
                o_aluOp   = c_ALU_ADD;
                o_illegal = (decodeTarget(i_op) == c_ST_FETCH);
            end
            c_ST_MEM_ADDR: begin
                o_aluSrcA = 1'b1;
                o_aluSrcB = c_SRCB_IMM;
                o_aluOp   = c_ALU_ADD;
            end
            c_ST_MEM_RD: begin
                o_iorD    = 1'b1;
                o_memRead = 1'b1;
            end
            c_ST_MEM_WB: begin
                o_regWrite = 1'b1;
                o_regDst   = c_REGDST_RT;
                o_memtoReg = 1'b1;
            end
            c_ST_MEM_WR: begin
                o_iorD     = 1'b1;
                o_memWrite = 1'b1;
            end
            c_ST_R_EXE: begin
                o_aluSrcA = 1'b1;
                o_aluSrcB = c_SRCB_REGB;
                o_aluOp   = c_ALU_RTYPE;
            end
            c_ST_R_WB: begin
                o_regWrite = 1'b1;
                o_regDst   = c_REGDST_RD;
            end
            c_ST_BRANCH: begin
                o_aluSrcA  = 1'b1;
                o_aluSrcB  = c_SRCB_REGB;
                o_aluOp    = c_ALU_SUB;
                o_pcSource = c_PCSRC_ALUOUT;
                o_pcWrite  = (i_op == c_OP_BEQ) ? i_zero :
                             (i_op == c_OP_BNE) ? ~i_zero : 1'b0;
            end
            c_ST_JUMP: begin
                o_pcSource = c_PCSRC_JUMP;
                o_pcWrite  = 1'b1;
            end
            c_ST_I_EXE: begin
                o_aluSrcA = 1'b1;
                o_aluSrcB = c_SRCB_IMM;
                o_aluOp   = iTypeAluOp(i_op);
            end
            c_ST_I_WB: begin
                o_regWrite = 1'b1;
                o_regDst   = c_REGDST_RT;
            end
            c_ST_JAL: begin
                if (c_JAL_EN) begin
                    o_regWrite = 1'b1;
                    o_regDst   = c_REGDST_RA;
                    o_memtoReg = 1'b0;
                    o_pcWrite  = 1'b1;
                    o_pcSource = c_PCSRC_JUMP;
                end
            end
            default: begin
                // HALT and unused encodings keep every strobe inactive
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/instr_sequencer.sv
// ============================================================================
// instr_sequencer : multicycle control FSM with memory-wait timeout to HALT
// Optional feature macro: JAL_EN (adds single-cycle JAL link-and-jump state)
// Revision: 1.0
// ============================================================================
`default_nettype none

module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int ALUOP_W     = 3,
    parameter int MEM_TIMEOUT = 15
)
(
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         OP,
    input  logic               Zero,
    input  logic               MemReady,
    output logic               PCWrite,
    output logic               IorD,
    output logic               IRWrite,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               MemtoReg,
    output logic               ALUSrcA,
    output logic               RegWrite,
    output logic [1:0]         PCSource,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         RegDst,
    output logic [ALUOP_W-1:0] ALUOp,
    output logic               Illegal,
    output logic               Fault,
    output logic [3:0]         State
);

    localparam int                c_CNT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(MEM_TIMEOUT - 1);

    if (ALUOP_W < 3) begin : g_aluOpWidthCheck
        $error("instr_sequencer: ALUOP_W must be at least 3");
    end

    state_t              r_state;
    state_t              w_nextState;
    logic [c_CNT_W-1:0]  r_waitCnt;
    logic                r_fault;
    logic                w_waiting;
    logic                w_timeout;
    logic [2:0]          w_aluOp;

    assign w_waiting = ((r_state == c_ST_FETCH) || (r_state == c_ST_MEM_RD) ||
                        (r_state == c_ST_MEM_WR)) && !MemReady;
    assign w_timeout = w_waiting && (r_waitCnt == c_CNT_LAST);

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            c_ST_FETCH:    if (MemReady) w_nextState = c_ST_DECODE;
            c_ST_DECODE:   w_nextState = decodeTarget(OP);
            c_ST_MEM_ADDR: w_nextState = (OP == c_OP_LW) ? c_ST_MEM_RD :
                                         (OP == c_OP_SW) ? c_ST_MEM_WR : c_ST_FETCH;
            c_ST_MEM_RD:   if (MemReady) w_nextState = c_ST_MEM_WB;
            c_ST_MEM_WR:   if (MemReady) w_nextState = c_ST_FETCH;
            c_ST_R_EXE:    w_nextState = c_ST_R_WB;
            c_ST_I_EXE:    w_nextState = c_ST_I_WB;
            c_ST_HALT:     w_nextState = c_ST_HALT;
            default:       w_nextState = c_ST_FETCH;
        endcase
        if (w_timeout) begin
            w_nextState = c_ST_HALT;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= c_ST_FETCH;
            r_waitCnt <= '0;
            r_fault   <= 1'b0;
        end else begin
            r_state <= w_nextState;
            if (w_nextState != r_state) begin
                r_waitCnt <= '0;
            end else if (w_waiting) begin
                r_waitCnt <= r_waitCnt + c_CNT_W'(1);
            end
            if (w_timeout) begin
                r_fault <= 1'b1;
            end
        end
    end

    seq_outdecode u_outdecode (
        .i_state    (r_state),
        .i_op       (OP),
        .i_zero     (Zero),
        .i_memReady (MemReady),
        .o_pcWrite  (PCWrite),
        .o_iorD     (IorD),
        .o_irWrite  (IRWrite),
        .o_memRead  (MemRead),
        .o_memWrite (MemWrite),
        .o_memtoReg (MemtoReg),
        .o_aluSrcA  (ALUSrcA),
        .o_regWrite (RegWrite),
        .o_pcSource (PCSource),
        .o_aluSrcB  (ALUSrcB),
        .o_regDst   (RegDst),
        .o_aluOp    (w_aluOp),
        .o_illegal  (Illegal)
    );

    assign ALUOp = ALUOP_W'(w_aluOp);
    assign Fault = r_fault;
    assign State = r_state;

endmodule

`default_nettype wire

// File: tb/tb_instr_sequencer.sv
// ============================================================================
// tb_instr_sequencer : directed stimulus, per-cycle reference model comparison
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_instr_sequencer;

    localparam int ALUOP_W     = 3;
    localparam int MEM_TIMEOUT = 15;
`ifdef JAL_EN
    localparam bit JAL_ON = 1'b1;
`else
    localparam bit JAL_ON = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               reset;
    logic [5:0]         OP;
    logic               Zero;
    logic               MemReady;
    logic               PCWrite, IorD, IRWrite, MemRead, MemWrite, MemtoReg, ALUSrcA, RegWrite;
    logic [1:0]         PCSource, ALUSrcB, RegDst;
    logic [ALUOP_W-1:0] ALUOp;
    logic               Illegal, Fault;
    logic [3:0]         State;

    int nVec = 0;
    int nMis = 0;

    always #5 clk = ~clk;

    instr_sequencer #(.ALUOP_W(ALUOP_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
        .clk(clk), .reset(reset), .OP(OP), .Zero(Zero), .MemReady(MemReady),
        .PCWrite(PCWrite), .IorD(IorD), .IRWrite(IRWrite), .MemRead(MemRead),
        .MemWrite(MemWrite), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
        .PCSource(PCSource), .ALUSrcB(ALUSrcB), .RegDst(RegDst), .ALUOp(ALUOp),
        .Illegal(Illegal), .Fault(Fault), .State(State)
    );

    typedef struct packed {
        logic       pcWrite, iorD, irWrite, memRead, memWrite, memtoReg, aluSrcA, regWrite;
        logic [1:0] pcSource, aluSrcB, regDst;
        logic [2:0] aluOp;
        logic       illegal;
    } outs_t;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nMis++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic bit isLegal(input logic [5:0] op);
        case (op)
            6'h00, 6'h02, 6'h04, 6'h05, 6'h08, 6'h0c, 6'h0d, 6'h0f, 6'h23, 6'h2b: return 1'b1;
            6'h03:   return JAL_ON;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int modelNext(input int st, input logic [5:0] op, input logic mr);
        case (st)
            0: return mr ? 1 : 0;
            1: begin
                if (!isLegal(op)) return 0;
                case (op)
                    6'h00: return 6;
                    6'h02: return 9;
                    6'h03: return 12;
                    6'h04, 6'h05: return 8;
                    6'h08, 6'h0c, 6'h0d, 6'h0f: return 10;
                    default: return 2;
                endcase
            end
            2:  return (op == 6'h23) ? 3 : (op == 6'h2b) ? 5 : 0;
            3:  return mr ? 4 : 3;
            5:  return mr ? 0 : 5;
            6:  return 7;
            10: return 11;
            15: return 15;
            default: return 0;
        endcase
    endfunction

    function automatic outs_t expOut(input int st, input logic [5:0] op, input logic z, input logic mr);
        outs_t o = '0;
        case (st)
            0: begin o.memRead = 1; o.aluSrcB = 2'b01; o.irWrite = mr; o.pcWrite = mr; end
            1: begin o.aluSrcB = 2'b11; o.illegal = !isLegal(op); end
            2: begin o.aluSrcA = 1; o.aluSrcB = 2'b10; end
            3: begin o.iorD = 1; o.memRead = 1; end
            4: begin o.regWrite = 1; o.memtoReg = 1; end
            5: begin o.iorD = 1; o.memWrite = 1; end
            6: begin o.aluSrcA = 1; o.aluOp = 3'b111; end
            7: begin o.regWrite = 1; o.regDst = 2'b01; end
            8: begin
                o.aluSrcA = 1; o.aluOp = 3'b001; o.pcSource = 2'b01;
                o.pcWrite = (op == 6'h04) ? z : (op == 6'h05) ? !z : 1'b0;
            end
            9: begin o.pcSource = 2'b10; o.pcWrite = 1; end
            10: begin
                o.aluSrcA = 1; o.aluSrcB = 2'b10;
                case (op)
                    6'h08:   o.aluOp = 3'b100;
                    6'h0d:   o.aluOp = 3'b101;
                    6'h0c:   o.aluOp = 3'b110;
                    6'h0f:   o.aluOp = 3'b011;
                    default: o.aluOp = 3'b000;
                endcase
            end
            11: o.regWrite = 1;
            12: if (JAL_ON) begin o.regWrite = 1; o.regDst = 2'b10; o.pcWrite = 1; o.pcSource = 2'b10; end
            default: ;
        endcase
        return o;
    endfunction

    int mState;
    int mWait;
    bit mFault;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mState <= 0;
            mWait  <= 0;
            mFault <= 1'b0;
        end else if ((mState == 0 || mState == 3 || mState == 5) && !MemReady) begin
            if (mWait + 1 >= MEM_TIMEOUT) begin
                mState <= 15;
                mFault <= 1'b1;
                mWait  <= 0;
            end else begin
                mWait <= mWait + 1;
            end
        end else begin
            mState <= modelNext(mState, OP, MemReady);
            mWait  <= 0;
        end
    end

    always @(negedge clk) begin : cmp
        outs_t e;
        outs_t a;
        e = expOut(mState, OP, Zero, MemReady);
        a = {PCWrite, IorD, IRWrite, MemRead, MemWrite, MemtoReg, ALUSrcA, RegWrite,
             PCSource, ALUSrcB, RegDst, ALUOp[2:0], Illegal};
        check("model_state", State, mState);
        check("model_fault", Fault, mFault);
        check("model_outputs", a, e);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        MemReady = 1'b0;
        for (int i = 0; i < 20 && State != 4'd0; i++) tick();
        check("idle_fetch", State, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1);
    end

    initial begin
        reset = 1'b0; OP = 6'h00; Zero = 1'b0; MemReady = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", State, 0);
        check("rst_fault", Fault, 0);
        check("rst_illegal", Illegal, 0);
        check("rst_memread", MemRead, 1);
        check("rst_srcb", ALUSrcB, 2'b01);
        reset = 1'b1;

        // R-type; OP change in R_EXE must be ignored
        idle();
        OP = 6'h00; MemReady = 1'b1;
        tick(); check("rt_decode", State, 1);
        tick(); check("rt_exe", State, 6); check("rt_exe_aluop", ALUOp, 3'b111);
        check("rt_exe_regwr", RegWrite, 0);
        OP = 6'h3f;
        tick(); check("rt_wb", State, 7); check("rt_wb_regwr", RegWrite, 1); check("rt_wb_dst", RegDst, 2'b01);
        tick(); check("rt_fetch", State, 0);

        // LW with three stalled MEM_RD cycles
        idle();
        OP = 6'h23; MemReady = 1'b1;
        tick(); MemReady = 1'b0;
        tick(); check("lw_addr", State, 2); check("lw_srcb", ALUSrcB, 2'b10);
        tick();
        for (int i = 0; i < 4; i++) begin
            check("lw_rd_state", State, 3);
            check("lw_rd_memread", MemRead, 1);
            if (i == 3) MemReady = 1'b1;
            tick();
        end
        check("lw_wb", State, 4); check("lw_wb_m2r", MemtoReg, 1); check("lw_wb_memread", MemRead, 0);
        tick(); check("lw_fetch", State, 0);

        // SW
        idle();
        OP = 6'h2b; MemReady = 1'b1;
        tick(); tick();
        tick(); check("sw_wr", State, 5); check("sw_memwrite", MemWrite, 1); check("sw_iord", IorD, 1);
        tick(); check("sw_fetch", State, 0);

        // BNE Zero=1, BNE Zero=0, BEQ Zero=1
        idle();
        OP = 6'h05; Zero = 1'b1; MemReady = 1'b1;
        tick(); tick(); check("bne_z1_state", State, 8); check("bne_z1_pcwrite", PCWrite, 0);
        tick();
        idle();
        OP = 6'h05; Zero = 1'b0; MemReady = 1'b1;
        tick(); tick(); check("bne_z0_pcwrite", PCWrite, 1); check("bne_z0_pcsrc", PCSource, 2'b01);
        tick();
        idle();
        OP = 6'h04; Zero = 1'b1; MemReady = 1'b1;
        tick(); tick(); check("beq_z1_pcwrite", PCWrite, 1); check("beq_aluop", ALUOp, 3'b001);
        tick();

        // I-type ORI and LUI, then jump
        idle();
        OP = 6'h0d; MemReady = 1'b1;
        tick(); tick(); check("ori_exe", State, 10); check("ori_aluop", ALUOp, 3'b101);
        tick(); check("ori_wb", State, 11); check("ori_regwr", RegWrite, 1); check("ori_dst", RegDst, 2'b00);
        tick();
        idle();
        OP = 6'h0f; MemReady = 1'b1;
        tick(); tick(); check("lui_aluop", ALUOp, 3'b011);
        tick(); tick();
        idle();
        OP = 6'h02; MemReady = 1'b1;
        tick(); tick(); check("j_state", State, 9); check("j_pcwrite", PCWrite, 1); check("j_pcsrc", PCSource, 2'b10);
        tick(); check("j_fetch", State, 0);

        // JAL
        idle();
        OP = 6'h03; MemReady = 1'b1;
        tick();
`ifdef JAL_EN
        check("jal_decode_illegal", Illegal, 0);
        tick(); check("jal_state", State, 12); check("jal_dst", RegDst, 2'b10);
        check("jal_regwr", RegWrite, 1); check("jal_pcsrc", PCSource, 2'b10);
        tick(); check("jal_fetch", State, 0);
`else
        check("jal_illegal", Illegal, 1);
        tick(); check("jal_fetch", State, 0); check("jal_illegal_end", Illegal, 0);
`endif

        // Unsupported opcode: one-cycle Illegal pulse
        idle();
        OP = 6'h3f; MemReady = 1'b1;
        tick(); check("ill_pulse", Illegal, 1); check("ill_decode", State, 1);
        tick(); check("ill_gone", Illegal, 0); check("ill_fetch", State, 0);

        // Reset mid-transaction abandons it
        idle();
        OP = 6'h23; MemReady = 1'b1;
        tick(); MemReady = 1'b0;
        tick(); tick(); check("mid_rd", State, 3);
        reset = 1'b0;
        #1; check("mid_rst_state", State, 0);
        tick(); reset = 1'b1;
        tick(); check("mid_after_rst", State, 0);

        // FETCH timeout: 15 stalled cycles then HALT with sticky Fault
        idle();
        OP = 6'h3f; MemReady = 1'b1;
        tick(); MemReady = 1'b0;
        tick();
        for (int i = 0; i < MEM_TIMEOUT; i++) begin
            check("to_wait_state", State, 0);
            check("to_wait_fault", Fault, 0);
            tick();
        end
        check("to_halt", State, 15); check("to_fault", Fault, 1);
        MemReady = 1'b1;
        tick(); check("halt_stuck", State, 15); check("halt_memread", MemRead, 0); check("halt_fault", Fault, 1);
        reset = 1'b0;
        #1; check("halt_rst_state", State, 0); check("halt_rst_fault", Fault, 0);
        tick(); reset = 1'b1;
        tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule

`default_nettype wire
